// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: accept, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (default is round-robin).
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int ALUC_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [ALUC_W-1:0] req0_aluc,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [ALUC_W-1:0] req1_aluc,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_s,
   output logic              rsp_z,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [ALUC_W-1:0] alu_aluc,
   input  logic [DATA_W-1:0] alu_s,
   input  logic              alu_z,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_gnt;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [ALUC_W-1:0] r_alu_aluc;
   logic [DATA_W-1:0] r_rsp_s;
   logic              r_rsp_z;
   logic              w_pick1;
   logic              w_accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_pick1 = req1_valid & ~req0_valid;
`else
   logic r_last;
   // r_last set means requester 1 was granted last, so requester 0 wins a tie.
   assign w_pick1 = req1_valid & (~req0_valid | ~r_last);
`endif

   assign w_accept = (r_state == IDLE) & (req0_valid | req1_valid);

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      busy       = (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            if (req0_valid | req1_valid) begin
               req0_ready = ~w_pick1;
               req1_ready = w_pick1;
               w_next     = EXEC;
            end
         end
         EXEC: w_next = RESP;
         RESP: begin
            rsp0_valid = ~r_gnt;
            rsp1_valid = r_gnt;
            if (r_gnt ? rsp1_ready : rsp0_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand registers drive the ALU directly, so its inputs only move on acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_gnt      <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_aluc <= '0;
         r_rsp_s    <= '0;
         r_rsp_z    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         r_last     <= 1'b1;
`endif
      end else begin
         if (w_accept) begin
            r_gnt      <= w_pick1;
            r_alu_a    <= w_pick1 ? req1_a    : req0_a;
            r_alu_b    <= w_pick1 ? req1_b    : req0_b;
            r_alu_aluc <= w_pick1 ? req1_aluc : req0_aluc;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last     <= w_pick1;
`endif
         end
         if (r_state == EXEC) begin
            r_rsp_s <= alu_s;
            r_rsp_z <= alu_z;
         end
      end
   end

   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_aluc = r_alu_aluc;
   assign rsp_s    = r_rsp_s;
   assign rsp_z    = r_rsp_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; supplies its own reference ALU and grant model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_aluc = '0, req1_aluc = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp_s, alu_a, alu_b, alu_s;
   logic        rsp_z, alu_z, busy;
   logic [3:0]  alu_aluc;

   int total = 0;
   int bad   = 0;
   logic m_last = 1'b1;

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a & b;
         4'd2:    return a | b;
         4'd3:    return a ^ b;
         4'd4:    return a - b;
         default: return b;
      endcase
   endfunction

   assign alu_s = ref_alu(alu_a, alu_b, alu_aluc);
   assign alu_z = (alu_s == 32'd0);

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(32), .ALUC_W(4)) dut (
      .clock(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_aluc(req0_aluc),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_aluc(req1_aluc),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_s(rsp_s), .rsp_z(rsp_z),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
      .alu_s(alu_s), .alu_z(alu_z), .busy(busy)
   );

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_last = 1'b1;
   endtask

   // One full transaction from IDLE; called at posedge+1.
   task automatic do_op(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                        input int hold, output logic g);
      logic ep, ez;
      logic [31:0] ea, eb, es;
      logic [3:0]  ec;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_aluc = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_aluc = c1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      ep = v1 && !v0;
`else
      ep = v1 && (!v0 || !m_last);
`endif
      g  = ep;
      ea = ep ? a1 : a0;
      eb = ep ? b1 : b0;
      ec = ep ? c1 : c0;
      es = ref_alu(ea, eb, ec);
      ez = (es == 32'd0);
      total++;
      if ({busy, req1_ready, req0_ready} !== {1'b0, ep, !ep}) begin
         bad++;
         $display("FAIL idle_grant: got busy,rdy1,rdy0=%b%b%b expected 0%b%b",
                  busy, req1_ready, req0_ready, ep, !ep);
      end
      @(posedge clk); #1;
      if (ep) req1_valid = 1'b0; else req0_valid = 1'b0;
      m_last = ep;
      #1;
      total++;
      if ({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 5'b10000 ||
          alu_a !== ea || alu_b !== eb || alu_aluc !== ec) begin
         bad++;
         $display("FAIL exec: got busy=%b rdy=%b%b vld=%b%b a=%h b=%h op=%h expected busy=1 rdy=00 vld=00 a=%h b=%h op=%h",
                  busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, alu_a, alu_b, alu_aluc,
                  ea, eb, ec);
      end
      @(posedge clk); #2;
      total++;
      if ({rsp1_valid, rsp0_valid} !== {ep, !ep} || rsp_s !== es || rsp_z !== ez ||
          {req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1) begin
         bad++;
         $display("FAIL resp: got vld=%b%b s=%h z=%b rdy=%b%b busy=%b expected vld=%b%b s=%h z=%b rdy=00 busy=1",
                  rsp1_valid, rsp0_valid, rsp_s, rsp_z, req1_ready, req0_ready, busy,
                  ep, !ep, es, ez);
      end
      if (ep) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #2;
         total++;
         if ({rsp1_valid, rsp0_valid} !== {ep, !ep} || rsp_s !== es || rsp_z !== ez ||
             {req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_hold: cycle %0d got vld=%b%b s=%h z=%b rdy=%b%b busy=%b expected vld=%b%b s=%h z=%b rdy=00 busy=1",
                     i, rsp1_valid, rsp0_valid, rsp_s, rsp_z, req1_ready, req0_ready, busy,
                     ep, !ep, es, ez);
         end
      end
      if (ep) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || {rsp1_valid, rsp0_valid} !== 2'b00 || alu_a !== ea ||
          alu_b !== eb || alu_aluc !== ec) begin
         bad++;
         $display("FAIL done_idle: got busy=%b vld=%b%b a=%h b=%h op=%h expected busy=0 vld=00 a=%h b=%h op=%h",
                  busy, rsp1_valid, rsp0_valid, alu_a, alu_b, alu_aluc, ea, eb, ec);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0_a = $urandom; req1_b = $urandom; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_z} !== 6'b0 ||
          rsp_s !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_aluc !== 4'd0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b rdy=%b%b vld=%b%b s=%h z=%b a=%h b=%h op=%h expected all zero",
                  busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_s, rsp_z,
                  alu_a, alu_b, alu_aluc);
      end
      do_reset();
   endtask

   task automatic test_single();
      logic g;
      do_reset();
      do_op(1'b1, 1'b0, 32'd5, 32'd3, 4'd0, 32'd0, 32'd0, 4'd0, 0, g);
      total++;
      if (g !== 1'b0) begin
         bad++;
         $display("FAIL single_grant: got %b expected 0", g);
      end
   endtask

   task automatic test_zero();
      logic g;
      do_op(1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'd7, 32'd7, 4'b0100, 1, g);
      total++;
      if (g !== 1'b1) begin
         bad++;
         $display("FAIL zero_grant: got %b expected 1", g);
      end
   endtask

   task automatic test_round_robin();
      logic g;
      logic [3:0] seq, want;
`ifdef ALU_ARB_FIXED_PRIO_EN
      want = 4'b0000;
`else
      want = 4'b1010;
`endif
      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_op(1'b1, 1'b1, $urandom, $urandom, 4'd0, $urandom, $urandom, 4'd3, 0, g);
         seq[i] = g;
      end
      total++;
      if (seq !== want) begin
         bad++;
         $display("FAIL grant_sequence: got (op3..op0) %b expected %b", seq, want);
      end
   endtask

   task automatic test_backpressure();
      logic g;
      do_reset();
      do_op(1'b1, 1'b1, 32'h1234, 32'h0F0F, 4'd2, 32'h5, 32'h6, 4'd0, 5, g);
   endtask

   task automatic test_reset_exec();
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_aluc = 4'd0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL exec_before_reset: got busy=%b expected 1", busy);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_last = 1'b1;
      #1;
      total++;
      if ({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_z} !== 6'b0 ||
          rsp_s !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_aluc !== 4'd0) begin
         bad++;
         $display("FAIL reset_in_exec: got busy=%b rdy=%b%b vld=%b%b s=%h z=%b a=%h b=%h op=%h expected all zero",
                  busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_s, rsp_z,
                  alu_a, alu_b, alu_aluc);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         total++;
         if ({busy, rsp1_valid, rsp0_valid} !== 3'b000) begin
            bad++;
            $display("FAIL no_rsp_after_abort: cycle %0d got busy=%b vld=%b%b expected 0 00",
                     i, busy, rsp1_valid, rsp0_valid);
         end
      end
   endtask

   task automatic test_random();
      logic g, v0, v1;
      logic [31:0] a0, b0, a1, b1;
      logic [3:0] c0, c1;
      for (int n = 0; n < 30; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
         c0 = 4'($urandom_range(0, 5)); c1 = 4'($urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) begin
            b0 = a0; c0 = 4'd4; b1 = a1; c1 = 4'd4;
         end
         do_op(v0, v1, a0, b0, c0, a1, b1, c1, int'($urandom_range(0, 3)), g);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_round_robin();
      test_backpressure();
      test_reset_exec();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL match the shared ALU datapath.
REQ-002 Parameter ALUC_W, default 4, ALU opcode width.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 reqN_a, reqN_b  input  DATA_W  operands from requester N.
REQ-008 reqN_aluc  input  ALUC_W  opcode from requester N.
REQ-009 rspN_valid  output  1  result available for requester N.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rsp_s  output  DATA_W  shared result bus, valid while either rspN_valid is high.
REQ-012 rsp_z  output  1  zero flag for the result on rsp_s.
REQ-013 alu_a, alu_b  output  DATA_W  operands driven to the shared combinational ALU.
REQ-014 alu_aluc  output  ALUC_W  opcode driven to the shared ALU.
REQ-015 alu_s  input  DATA_W  ALU result; alu_z  input  1  ALU zero flag.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 IDLE: the arbiter SHALL raise reqN_ready only for the grant winner among asserted reqN_valid; never both.
REQ-019 Acceptance occurs on a cycle with reqN_valid and reqN_ready high; a, b and aluc SHALL be latched, grant ID recorded, and the FSM SHALL go to EXEC.
REQ-020 EXEC (one cycle): alu_a/alu_b/alu_aluc SHALL drive the latched values; alu_s/alu_z SHALL be registered at end of cycle; next state RESP.
REQ-021 Outside EXEC, alu_a, alu_b and alu_aluc SHALL hold their last driven values (no toggling while idle).
REQ-022 RESP: rspG_valid SHALL be high for granted requester G only; rsp_s/rsp_z SHALL be stable until rspG_ready is sampled high.
REQ-023 On rspG_valid and rspG_ready, the FSM SHALL return to IDLE; a new acceptance SHALL be possible on the next cycle (no same-cycle overlap).
REQ-024 Latency: acceptance at cycle N SHALL give rspG_valid from cycle N+2; peak throughput one operation per three cycles.
REQ-025 Both reqN_ready SHALL be low in EXEC and RESP; requests SHALL wait without loss.
REQ-026 Default (round-robin): a last-grant pointer SHALL favour the requester not granted last; with only one valid, that one SHALL win.
REQ-027 rspN_ready asserted without rspN_valid SHALL be ignored.
REQ-028 Results SHALL be passed unmodified; the arbiter SHALL not interpret aluc.

Reset
REQ-029 With reset high at a clock edge: state IDLE, last-grant pointer = 1 (requester 0 wins first tie), all rspN_valid/reqN_ready/busy = 0, rsp_s = 0, rsp_z = 0, alu_a = alu_b = 0, alu_aluc = 0.
REQ-030 Reset mid-operation (EXEC or RESP) SHALL abort the operation; no response is delivered.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 SHALL always win ties and the last-grant pointer SHALL be absent; undefined -> round-robin per REQ-026.

Verification
REQ-032 Single request: req0 a=5, b=3, aluc=0000, ALU sums -> rsp0_valid two cycles after accept, rsp_s=8, rsp_z=0.
REQ-033 Zero result: req1 a=7, b=7, aluc=0100 -> rsp1_valid only, rsp_s=0, rsp_z=1.
REQ-034 Both valid continuously, round-robin -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-035 Back-pressure: rsp0_ready low 5 cycles -> rsp0_valid and rsp_s held, both reqN_ready low, busy=1.
REQ-036 Reset asserted in EXEC -> next cycle IDLE, all outputs at reset values, no rsp_valid pulse.
